// File: rtl/ap600_key_encoder.sv
// ap600_key_encoder
// Turns the four active-low 5-bit push-switch rows of the AP600 into debounced,
// one-per-press key codes. The codes are queued for the calculator core behind
// a show-ahead valid/ready FIFO.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   pswA..pswD push-switch rows A..D, active-low, 5 bits each
//   key_ready  core takes the head entry this cycle
//   key_valid  queue not empty
//   key_code   head-of-queue key code (0 while empty)
//   key_ovf    sticky: a key was accepted while the queue was full
//   key_busy   scanner not idle
module ap600_key_encoder #(
  parameter int unsigned DEB_CYCLES = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] pswA,
  input  logic [4:0] pswB,
  input  logic [4:0] pswC,
  input  logic [4:0] pswD,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [4:0] key_code,
  output logic       key_ovf,
  output logic       key_busy
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_e;

  // Switch index = row*5 + column, rows A=0, B=1, C=2, D=3.
  function automatic logic [4:0] map_code(input logic [4:0] idx);
    case (idx)
      5'd0:    map_code = 5'd7;   // A0
      5'd1:    map_code = 5'd8;   // A1
      5'd2:    map_code = 5'd9;   // A2
      5'd3:    map_code = 5'd13;  // A3 divide
      5'd4:    map_code = 5'd17;  // A4 CLR
      5'd5:    map_code = 5'd4;   // B0
      5'd6:    map_code = 5'd5;   // B1
      5'd7:    map_code = 5'd6;   // B2
      5'd8:    map_code = 5'd12;  // B3 multiply
      5'd9:    map_code = 5'd18;  // B4 BS
      5'd10:   map_code = 5'd1;   // C0
      5'd11:   map_code = 5'd2;   // C1
      5'd12:   map_code = 5'd3;   // C2
      5'd13:   map_code = 5'd11;  // C3 minus
      5'd14:   map_code = 5'd14;  // C4 power
      5'd15:   map_code = 5'd0;   // D0
      5'd16:   map_code = 5'd15;  // D1 log
      5'd17:   map_code = 5'd19;  // D2 sign
      5'd18:   map_code = 5'd10;  // D3 plus
      5'd19:   map_code = 5'd16;  // D4 equals
      default: map_code = 5'd0;
    endcase
  endfunction

  // Input conditioning: invert to active-high, two-flop synchronizer.
  logic [19:0] sync1_q, vec_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      vec_q   <= '0;
    end else begin
      sync1_q <= ~{pswD, pswC, pswB, pswA};
      vec_q   <= sync1_q;
    end
  end

  logic       is_onehot;
  logic [4:0] hot_idx;

  always_comb begin
    is_onehot = (vec_q != '0) && ((vec_q & (vec_q - 20'd1)) == '0);
    hot_idx   = '0;
    for (int unsigned i = 0; i < 20; i++) begin
      if (vec_q[i]) hot_idx = 5'(i);
    end
  end

  // Scanner FSM.
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [19:0]   onehot_q, onehot_d;
  logic [4:0]    code_q, code_d;
  logic          accept;
  logic [4:0]    push_code;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    onehot_d  = onehot_q;
    code_d    = code_q;
    accept    = 1'b0;
    push_code = code_q;
    cnt_inc   = (cnt_q >= DEB_MAX) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (is_onehot) begin
          onehot_d = vec_q;
          code_d   = map_code(hot_idx);
          cnt_d    = CW'(1);
          if (DEB_CYCLES == 1) begin
            // Single-sample debounce: the latch is bypassed so the code is pushed now.
            accept    = 1'b1;
            push_code = map_code(hot_idx);
            state_d   = HELD;
          end else begin
            state_d = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (vec_q == onehot_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEB_MAX) begin
            accept  = 1'b1;
            state_d = HELD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      HELD: begin
        if (vec_q == '0) begin
          cnt_d   = CW'(1);
          state_d = (DEB_CYCLES == 1) ? IDLE : RELEASE;
        end
      end
      RELEASE: begin
        if (vec_q == '0) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DEB_MAX) state_d = IDLE;
        end else begin
          state_d = HELD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      code_q   <= code_d;
    end
  end

  // Key FIFO, show-ahead, pointers one bit wider than the address.
  logic [4:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        ovf_q;
  logic        empty, full, pop, push;

  always_comb begin
    empty = (wr_q == rd_q);
    full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop   = !empty && key_ready;
    // A pop in the same cycle frees the slot, so a full queue still takes the push.
    push  = accept && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= push_code;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (accept && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign key_valid = !empty;
  assign key_code  = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign key_ovf   = ovf_q;
  assign key_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_ap600_key_encoder.sv
module tb_ap600_key_encoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] pswA, pswB, pswC, pswD;
  logic       key_ready;
  logic       v0, o0, b0, v1, o1, b1;
  logic [4:0] c0, c1;

  always #5 clk = ~clk;

  ap600_key_encoder #(.DEB_CYCLES(1), .FIFO_DEPTH(DEPTH)) u_deb1 (
    .clk(clk), .reset(reset),
    .pswA(pswA), .pswB(pswB), .pswC(pswC), .pswD(pswD),
    .key_ready(key_ready),
    .key_valid(v0), .key_code(c0), .key_ovf(o0), .key_busy(b0)
  );

  ap600_key_encoder #(.DEB_CYCLES(4), .FIFO_DEPTH(DEPTH)) u_deb4 (
    .clk(clk), .reset(reset),
    .pswA(pswA), .pswB(pswB), .pswC(pswC), .pswD(pswD),
    .key_ready(key_ready),
    .key_valid(v1), .key_code(c1), .key_ovf(o1), .key_busy(b1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: keys as a 20-bit pressed set (bit row*5+col, row A=0..D=3),
  // a two-sample delay line, a press candidate, a release-wait lock and a code queue.
  int          deb_of [2];
  int          code_tab [4][5];
  logic [19:0] pressed;
  logic [19:0] d1 [2];
  logic [19:0] d2 [2];
  logic [19:0] cval [2];
  bit          cand [2];
  bit          locked [2];
  bit          ovf_m [2];
  int          clen [2];
  int          zrun [2];
  int          fq [2][$];
  int          obs [2][$];
  int          e [$];

  function automatic int code_of(input logic [19:0] s);
    code_of = -1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        if (s[r*5+c]) code_of = code_tab[r][c];
  endfunction

  function automatic logic [19:0] kb(input int r, input int c);
    logic [19:0] one;
    one = 20'd1;
    kb = one << (r*5 + c);
  endfunction

  task automatic model_reset(input int i);
    d1[i] = '0; d2[i] = '0; cval[i] = '0;
    cand[i] = 1'b0; locked[i] = 1'b0; ovf_m[i] = 1'b0;
    clen[i] = 0; zrun[i] = 0;
    fq[i].delete();
  endtask

  task automatic model_step(input int i);
    logic [19:0] s;
    bit acc;
    bit pop;
    s   = d2[i];
    acc = 1'b0;
    pop = (fq[i].size() > 0) && key_ready;
    if (locked[i]) begin
      // A key was taken: wait for deb consecutive empty samples.
      if (s == '0) begin
        zrun[i]++;
        if (zrun[i] >= deb_of[i]) locked[i] = 1'b0;
      end else begin
        zrun[i] = 0;
      end
    end else if (cand[i]) begin
      if (s == cval[i]) begin
        clen[i]++;
        if (clen[i] >= deb_of[i]) begin
          acc = 1'b1; cand[i] = 1'b0; locked[i] = 1'b1; zrun[i] = 0;
        end
      end else begin
        cand[i] = 1'b0;
      end
    end else if ($countones(s) == 1) begin
      cval[i] = s;
      clen[i] = 1;
      if (deb_of[i] <= 1) begin
        acc = 1'b1; locked[i] = 1'b1; zrun[i] = 0;
      end else begin
        cand[i] = 1'b1;
      end
    end
    if (pop) void'(fq[i].pop_front());
    if (acc) begin
      if (fq[i].size() < DEPTH) fq[i].push_back(code_of(s));
      else ovf_m[i] = 1'b1;
    end
    d2[i] = d1[i];
    d1[i] = pressed;
  endtask

  task automatic compare_outputs();
    for (int i = 0; i < 2; i++) begin
      logic       v, o, b;
      logic [4:0] c;
      int         ecode;
      v = (i == 0) ? v0 : v1;
      o = (i == 0) ? o0 : o1;
      b = (i == 0) ? b0 : b1;
      c = (i == 0) ? c0 : c1;
      ecode = (fq[i].size() > 0) ? fq[i][0] : 0;
      check($sformatf("valid%0d", i), int'(v), int'(fq[i].size() > 0));
      check($sformatf("code%0d", i), int'(c), ecode);
      check($sformatf("ovf%0d", i), int'(o), int'(ovf_m[i]));
      check($sformatf("busy%0d", i), int'(b), int'(cand[i] || locked[i]));
    end
  endtask

  task automatic tick();
    if (v0 && key_ready) obs[0].push_back(int'(c0));
    if (v1 && key_ready) obs[1].push_back(int'(c1));
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!reset) model_reset(i);
      else model_step(i);
    end
    #1;
    compare_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic set_keys(input logic [19:0] k);
    pressed = k;
    pswA = ~k[4:0];
    pswB = ~k[9:5];
    pswC = ~k[14:10];
    pswD = ~k[19:15];
  endtask

  task automatic tap(input int r, input int c);
    set_keys(kb(r, c)); tick();
    set_keys('0);       tick();
  endtask

  task automatic clear_logs();
    obs[0].delete();
    obs[1].delete();
  endtask

  task automatic compare_log(input string tag, input int inst);
    check({tag, "_count"}, obs[inst].size(), e.size());
    for (int k = 0; k < e.size() && k < obs[inst].size(); k++)
      check($sformatf("%s_%0d", tag, k), obs[inst][k], e[k]);
  endtask

  initial begin
    deb_of[0] = 1;
    deb_of[1] = 4;
    code_tab = '{'{7, 8, 9, 13, 17},
                 '{4, 5, 6, 12, 18},
                 '{1, 2, 3, 11, 14},
                 '{0, 15, 19, 10, 16}};
    reset = 1'b0;
    key_ready = 1'b1;
    set_keys('0);
    model_reset(0);
    model_reset(1);
    #1;
    check("reset_valid", int'(v0), 0);
    check("reset_code", int'(c0), 0);
    check("reset_ovf", int'(o0), 0);
    check("reset_busy", int'(b1), 0);
    run(3);
    #2 reset = 1'b1;
    run(2);

    // Single key C0 then D0.
    clear_logs();
    tap(2, 0); run(6);
    e = '{1};   compare_log("c0_deb1", 0);
    e.delete(); compare_log("c0_deb4", 1);
    clear_logs();
    tap(3, 0); run(6);
    e = '{0};   compare_log("d0_deb1", 0);

    // Key sequence: log 1 0 + 5 =.
    clear_logs();
    tap(3, 1); tap(2, 0); tap(3, 0); tap(3, 3); tap(1, 1); tap(3, 4);
    run(6);
    e = '{15, 1, 0, 10, 5, 16}; compare_log("seq", 0);
    check("seq_ovf", int'(o0), 0);

    // Backpressure and overflow.
    clear_logs();
    key_ready = 1'b0;
    tap(0, 0); tap(0, 1); tap(0, 2); tap(3, 3); tap(2, 3);
    run(4);
    check("bp_valid", int'(v0), 1);
    check("bp_code", int'(c0), 7);
    check("bp_ovf", int'(o0), 1);
    key_ready = 1'b1;
    run(8);
    e = '{7, 8, 9, 10}; compare_log("bp", 0);

    // Debounce on the DEB_CYCLES=4 instance.
    clear_logs();
    set_keys(kb(1, 1)); run(3);
    set_keys('0);       run(8);
    e.delete(); compare_log("deb_short", 1);
    set_keys(kb(1, 1)); run(8);
    set_keys('0);       run(8);
    for (int k = 0; k < 50; k++) begin
      if ((k % 10) == 5 || (k % 10) == 6) set_keys('0);
      else set_keys(kb(1, 1));
      tick();
    end
    set_keys('0); run(8);
    e = '{5, 5}; compare_log("deb_long", 1);

    // Rollover rejection.
    clear_logs();
    set_keys(kb(0, 0) | kb(0, 1)); run(6);
    set_keys('0);                  run(8);
    e.delete(); compare_log("roll_both0", 0);
    compare_log("roll_both1", 1);
    set_keys(kb(0, 0));            run(6);
    set_keys(kb(0, 0) | kb(0, 1)); run(6);
    set_keys('0);                  run(8);
    e = '{7}; compare_log("roll_seq0", 0);
    compare_log("roll_seq1", 1);

    // Randomised presses, rollovers, gaps and backpressure.
    for (int n = 0; n < 80; n++) begin
      int kind;
      logic [19:0] k;
      kind = $urandom_range(0, 9);
      k = kb($urandom_range(0, 3), $urandom_range(0, 4));
      if (kind == 7) k = k | kb($urandom_range(0, 3), $urandom_range(0, 4));
      if (kind >= 8) k = '0;
      key_ready = ($urandom_range(0, 9) < 7);
      set_keys(k);
      run($urandom_range(1, 8));
    end
    set_keys('0);
    key_ready = 1'b1;
    run(12);

    // Reset while a key is held with two entries queued.
    key_ready = 1'b0;
    tap(0, 0);
    set_keys(kb(1, 2));
    run(4);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid0", int'(v0), 0);
    check("midrst_code0", int'(c0), 0);
    check("midrst_ovf0", int'(o0), 0);
    check("midrst_busy0", int'(b0), 0);
    check("midrst_valid1", int'(v1), 0);
    check("midrst_busy1", int'(b1), 0);
    for (int i = 0; i < 2; i++) model_reset(i);
    clear_logs();
    run(2);
    #2 reset = 1'b1;
    key_ready = 1'b1;
    run(10);
    set_keys('0);
    run(8);
    e = '{6}; compare_log("midrst_deb1", 0);
    compare_log("midrst_deb4", 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
